// File: rtl/mdio_responder.sv
// Clause 22 MDIO management responder with a 32 x 16 register file, local read port and write notify.
// Build option: define MDIO_RESP_PREAMBLE_SUPPRESS_EN to accept frames without a 32-bit preamble.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1550
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [4:0]  loc_addr,
  output logic [15:0] loc_rdata,
  output logic        wr_pulse,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 32;
  localparam int unsigned CW   = 6;
  localparam logic [CW-1:0] PRE_MAX = CW'(32);

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
  localparam logic PRE_SUPPRESS = 1'b1;
`else
  localparam logic PRE_SUPPRESS = 1'b0;
`endif

  typedef enum logic [2:0] {PRE, ST1, OP, PHYAD, REGAD, TA, DATA} state_t;

  logic [2:0]    mdc_q;
  logic [1:0]    mdio_q;
  logic          rise_c;
  logic          bit_c;
  state_t        state;
  logic [CW-1:0] pre_cnt;
  logic [3:0]    bit_cnt;
  logic [1:0]    op_q;
  logic [AW-2:0] phy_q;
  logic [AW-1:0] reg_q;
  logic          match;
  logic          is_rd;
  logic [DW-1:0] shift_q;
  logic [DW-1:0] regs [NREG];

  logic [AW-1:0] reg_next_c;
  logic [DW-1:0] rd_word_c;
  logic [DW-1:0] loc_word_c;
  logic [DW-1:0] wdata_c;
  logic          rd_act_c;
  logic          ro_c;

  assign rise_c   = mdc_q[1] & ~mdc_q[2];
  assign bit_c    = mdio_q[1];
  assign wdata_c  = {shift_q[DW-2:0], bit_c};
  assign rd_act_c = match & is_rd;
  assign ro_c     = (reg_q == AW'(2)) || (reg_q == AW'(3));

  // Register file read muxes: ID registers are constants, the rest come from storage
  always_comb begin
    reg_next_c = {reg_q[AW-2:0], bit_c};
    case (reg_next_c)
      AW'(2):  rd_word_c = PHY_ID1;
      AW'(3):  rd_word_c = PHY_ID2;
      default: rd_word_c = regs[reg_next_c];
    endcase
    case (loc_addr)
      AW'(2):  loc_word_c = PHY_ID1;
      AW'(3):  loc_word_c = PHY_ID2;
      default: loc_word_c = regs[loc_addr];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      // MDC sync resets high so a pin already high after reset does not look like a rise
      mdc_q     <= 3'b111;
      mdio_q    <= 2'b11;
      state     <= PRE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      op_q      <= '0;
      phy_q     <= '0;
      reg_q     <= '0;
      match     <= 1'b0;
      is_rd     <= 1'b0;
      shift_q   <= '0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      loc_rdata <= '0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      mdc_q     <= {mdc_q[1:0], mdc};
      mdio_q    <= {mdio_q[0], mdio_i};
      wr_pulse  <= 1'b0;
      loc_rdata <= loc_word_c;
      if (rise_c) begin
        case (state)
          PRE: begin
            if (bit_c) begin
              if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + CW'(1);
            end else begin
              pre_cnt <= '0;
              if (pre_cnt == PRE_MAX || PRE_SUPPRESS) state <= ST1;
            end
          end
          ST1: begin
            bit_cnt <= '0;
            state   <= bit_c ? OP : PRE;
          end
          OP: begin
            op_q <= {op_q[0], bit_c};
            if (bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              state   <= PHYAD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          PHYAD: begin
            phy_q <= {phy_q[AW-3:0], bit_c};
            if (bit_cnt == 4'd4) begin
              match   <= (op_q == 2'b10 || op_q == 2'b01) && ({phy_q, bit_c} == PHY_ADDR);
              is_rd   <= (op_q == 2'b10);
              bit_cnt <= '0;
              state   <= REGAD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          REGAD: begin
            reg_q <= reg_next_c;
            if (bit_cnt == 4'd4) begin
              if (rd_act_c) shift_q <= rd_word_c;
              bit_cnt <= '0;
              state   <= TA;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          TA: begin
            if (bit_cnt == 4'd0) begin
              if (rd_act_c) begin
                mdio_oe <= 1'b1;
                mdio_o  <= 1'b0;
              end
              bit_cnt <= 4'd1;
            end else begin
              if (rd_act_c) mdio_o <= shift_q[DW-1];
              shift_q <= wdata_c;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            // One shift register serves both directions: MSB goes out, sampled bit comes in
            shift_q <= wdata_c;
            if (bit_cnt == 4'd15) begin
              if (rd_act_c) begin
                mdio_oe <= 1'b0;
                mdio_o  <= 1'b1;
              end else if (match && !ro_c) begin
                regs[reg_q] <= wdata_c;
                wr_pulse    <= 1'b1;
                wr_addr     <= reg_q;
                wr_data     <= wdata_c;
              end
              bit_cnt <= '0;
              pre_cnt <= '0;
              state   <= PRE;
            end else begin
              if (rd_act_c) mdio_o <= shift_q[DW-1];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          default: begin
            pre_cnt <= '0;
            state   <= PRE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Table-driven bench for mdio_responder: an MDIO master model issues frames and checks drive, data and write notify.
`timescale 1ns/1ps
module tb_mdio_responder;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        mst = 1'b1;
  logic        mdio_o, mdio_oe;
  logic        line;
  logic [4:0]  loc_addr = 5'd0;
  logic [15:0] loc_rdata;
  logic        wr_pulse;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int n_chk = 0;
  int n_fail = 0;

  assign line = mdio_oe ? mdio_o : mst;

  always #5 clk = ~clk;

  mdio_responder dut (
    .clk(clk), .arst_n(arst_n), .mdc(mdc), .mdio_i(line),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .loc_addr(loc_addr), .loc_rdata(loc_rdata),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Write-notify monitor, also captures loc_rdata at and after the pulse
  int          pulse_cnt = 0;
  logic [15:0] at_pulse = '0;
  logic [15:0] after_pulse = '0;
  logic        cap_next = 1'b0;
  always @(negedge clk) begin
    if (wr_pulse) begin
      pulse_cnt <= pulse_cnt + 1;
      at_pulse  <= loc_rdata;
      cap_next  <= 1'b1;
    end else if (cap_next) begin
      after_pulse <= loc_rdata;
      cap_next    <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Master frame: preamble, ST, OP, PHYAD, REGAD, TA, DATA; samples the line before each rise
  task automatic do_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] wd, input int limit,
                          output int oe_cnt, output logic ta, output logic [15:0] rd);
    bit q[$];
    int n;
    int j;
    logic rdf;
    rdf = (op == 2'b10);
    for (int i = 0; i < pre; i++) q.push_back(1'b1);
    q.push_back(1'b0); q.push_back(1'b1);
    q.push_back(op[1]); q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    q.push_back(1'b1); q.push_back(rdf ? 1'b1 : 1'b0);
    for (int i = 15; i >= 0; i--) q.push_back(rdf ? 1'b1 : wd[i]);
    n = (limit > 0 && limit < q.size()) ? limit : q.size();
    oe_cnt = 0;
    ta = 1'b1;
    rd = '1;
    for (int i = 0; i < n; i++) begin
      mdc = 1'b0;
      mst = q[i];
      #HALF;
      j = i - pre;
      oe_cnt += int'(mdio_oe);
      if (j == 15) ta = line;
      if (j >= 16 && j <= 31) rd[31 - j] = line;
      mdc = 1'b1;
      #HALF;
    end
    if (n == q.size()) oe_cnt += int'(mdio_oe);
    mst = 1'b1;
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] wd;
    int          e_oe;
    logic [15:0] e_rd;
    int          e_pulse;
    logic [4:0]  e_wa;
    logic [15:0] e_wd;
  } vec_t;

  vec_t tv[14];

  task automatic loc_chk(input string nm, input logic [4:0] a, input logic [15:0] exp);
    loc_addr = a;
    @(posedge clk); #1;
    chk(nm, 32'(loc_rdata), 32'(exp));
  endtask

  initial begin
    int          oe_cnt;
    int          p0;
    logic        ta;
    logic [15:0] rd;
    int          sup_oe;

`ifdef MDIO_RESP_PREAMBLE_SUPPRESS_EN
    sup_oe = 17;
`else
    sup_oe = 0;
`endif
    tv[0]  = '{32, 2'b10, 5'd1, 5'd2, 16'h0000, 17, 16'h0022, 0, 5'd0, 16'h0000};
    tv[1]  = '{32, 2'b01, 5'd1, 5'd5, 16'hBEEF, 0,  16'h0000, 1, 5'd5, 16'hBEEF};
    tv[2]  = '{32, 2'b10, 5'd1, 5'd5, 16'h0000, 17, 16'hBEEF, 0, 5'd5, 16'hBEEF};
    tv[3]  = '{32, 2'b01, 5'd1, 5'd3, 16'h1234, 0,  16'h0000, 0, 5'd5, 16'hBEEF};
    tv[4]  = '{32, 2'b10, 5'd1, 5'd3, 16'h0000, 17, 16'h1550, 0, 5'd5, 16'hBEEF};
    tv[5]  = '{32, 2'b01, 5'd2, 5'd7, 16'h1234, 0,  16'h0000, 0, 5'd5, 16'hBEEF};
    tv[6]  = '{32, 2'b10, 5'd1, 5'd7, 16'h0000, 17, 16'h0000, 0, 5'd5, 16'hBEEF};
    tv[7]  = '{31, 2'b10, 5'd1, 5'd2, 16'h0000, sup_oe, 16'h0022, 0, 5'd5, 16'hBEEF};
    tv[8]  = '{0,  2'b10, 5'd1, 5'd3, 16'h0000, sup_oe, 16'h1550, 0, 5'd5, 16'hBEEF};
    tv[9]  = '{32, 2'b11, 5'd1, 5'd9, 16'hAAAA, 0,  16'h0000, 0, 5'd5, 16'hBEEF};
    tv[10] = '{32, 2'b00, 5'd1, 5'd9, 16'hAAAA, 0,  16'h0000, 0, 5'd5, 16'hBEEF};
    tv[11] = '{32, 2'b01, 5'd1, 5'd9, 16'h5555, 0,  16'h0000, 1, 5'd9, 16'h5555};
    tv[12] = '{32, 2'b10, 5'd1, 5'd9, 16'h0000, 17, 16'h5555, 0, 5'd9, 16'h5555};
    tv[13] = '{32, 2'b10, 5'd2, 5'd9, 16'h0000, 0,  16'h0000, 0, 5'd9, 16'h5555};

    repeat (4) @(posedge clk);
    #2;
    chk("rst_oe", 32'(mdio_oe), 32'd0);
    chk("rst_o", 32'(mdio_o), 32'd1);
    chk("rst_pulse", 32'(wr_pulse), 32'd0);
    chk("rst_waddr", 32'(wr_addr), 32'd0);
    chk("rst_wdata", 32'(wr_data), 32'd0);
    chk("rst_loc", 32'(loc_rdata), 32'd0);
    arst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    for (int i = 0; i < 14; i++) begin
      p0 = pulse_cnt;
      do_frame(tv[i].pre, tv[i].op, tv[i].phy, tv[i].ra, tv[i].wd, 0, oe_cnt, ta, rd);
      repeat (4) @(posedge clk);
      #2;
      chk($sformatf("v%0d_oe_periods", i), 32'(oe_cnt), 32'(tv[i].e_oe));
      if (tv[i].e_oe == 17) begin
        chk($sformatf("v%0d_ta", i), 32'(ta), 32'd0);
        chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(tv[i].e_rd));
      end
      chk($sformatf("v%0d_pulses", i), 32'(pulse_cnt - p0), 32'(tv[i].e_pulse));
      chk($sformatf("v%0d_waddr", i), 32'(wr_addr), 32'(tv[i].e_wa));
      chk($sformatf("v%0d_wdata", i), 32'(wr_data), 32'(tv[i].e_wd));
    end

    loc_chk("loc_r5", 5'd5, 16'hBEEF);
    loc_chk("loc_r2", 5'd2, 16'h0022);
    loc_chk("loc_r3", 5'd3, 16'h1550);
    loc_chk("loc_r7", 5'd7, 16'h0000);

    // Local read of the address being written in the same cycle returns old then new data
    loc_addr = 5'd11;
    p0 = pulse_cnt;
    do_frame(32, 2'b01, 5'd1, 5'd11, 16'hCAFE, 0, oe_cnt, ta, rd);
    repeat (4) @(posedge clk);
    #2;
    chk("same_cyc_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("same_cyc_old", 32'(at_pulse), 32'h0000);
    chk("same_cyc_new", 32'(after_pulse), 32'hCAFE);

    // Reset during D8 of a read
    do_frame(32, 2'b10, 5'd1, 5'd2, 16'h0000, 32 + 24, oe_cnt, ta, rd);
    chk("mid_rst_oe_before", 32'(mdio_oe), 32'd1);
    arst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_oe_after", 32'(mdio_oe), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_waddr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wdata", 32'(wr_data), 32'd0);
    loc_chk("mid_rst_r5", 5'd5, 16'h0000);
    loc_chk("mid_rst_r11", 5'd11, 16'h0000);
    loc_chk("mid_rst_r2", 5'd2, 16'h0022);
    #3;
    do_frame(32, 2'b10, 5'd1, 5'd3, 16'h0000, 0, oe_cnt, ta, rd);
    chk("post_rst_oe_periods", 32'(oe_cnt), 32'd17);
    chk("post_rst_rdata", 32'(rd), 32'h1550);
    do_frame(32, 2'b10, 5'd1, 5'd9, 16'h0000, 0, oe_cnt, ta, rd);
    chk("post_rst_r9", 32'(rd), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
